bypass_controller: RTL and testbench

Register-read-stage bypass controller. Tracks the destination physical registers of in-flight integer and memory (load) instructions across the execute/memory-access and writeback stages. Compares each issuing consumer's source operands against them and produces a registered `BypassControll` word per consumer lane. The execute-stage operand muxes consume that word in the following cycle.

---
 rtl/bypass_controller.sv | 139 +++++++++++++
 tb/tb_bypass_controller.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/bypass_controller.sv
// Register-read bypass controller: tracks in-flight integer/load destinations for
// two stages and emits a registered per-consumer {rA, rB} bypass select word.
module bypass_controller #(
    parameter int INT_LANES  = 2,
    parameter int MEM_LANES  = 2,
    parameter int CONS_LANES = 4,
    parameter int PREG_WIDTH = 7,
    localparam int ILW   = (INT_LANES > 1) ? $clog2(INT_LANES) : 1,
    localparam int MLW   = (MEM_LANES > 1) ? $clog2(MEM_LANES) : 1,
    localparam int SEL_W = 1 + 2 + ILW + MLW + 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             stall,
    input  logic                             flush,
    input  logic [INT_LANES-1:0]             intDstValid,
    input  logic [INT_LANES*PREG_WIDTH-1:0]  intDstPreg,
    input  logic [MEM_LANES-1:0]             memDstValid,
    input  logic [MEM_LANES*PREG_WIDTH-1:0]  memDstPreg,
    input  logic [CONS_LANES-1:0]            srcAValid,
    input  logic [CONS_LANES*PREG_WIDTH-1:0] srcAPreg,
    input  logic [CONS_LANES-1:0]            srcBValid,
    input  logic [CONS_LANES*PREG_WIDTH-1:0] srcBPreg,
    output logic [CONS_LANES*2*SEL_W-1:0]    bypassCtrl
);

    localparam logic [1:0] STG_INT_EX = 2'd0;
    localparam logic [1:0] STG_INT_WB = 2'd1;
    localparam logic [1:0] STG_MEM_MA = 2'd2;
    localparam logic [1:0] STG_MEM_WB = 2'd3;

    typedef struct packed {
        logic           valid;
        logic [1:0]     stg;
        logic [ILW-1:0] intLane;
        logic [MLW-1:0] memLane;
        logic           complexLane;
    } bypass_select_t;

    logic [INT_LANES-1:0][PREG_WIDTH-1:0]  int_dst_p;
    logic [MEM_LANES-1:0][PREG_WIDTH-1:0]  mem_dst_p;
    logic [CONS_LANES-1:0][PREG_WIDTH-1:0] src_a_p;
    logic [CONS_LANES-1:0][PREG_WIDTH-1:0] src_b_p;

    assign int_dst_p = intDstPreg;
    assign mem_dst_p = memDstPreg;
    assign src_a_p   = srcAPreg;
    assign src_b_p   = srcBPreg;

    logic [INT_LANES-1:0]                  iex_v, iwb_v;
    logic [INT_LANES-1:0][PREG_WIDTH-1:0]  iex_p, iwb_p;
    logic [MEM_LANES-1:0]                  mma_v, mwb_v;
    logic [MEM_LANES-1:0][PREG_WIDTH-1:0]  mma_p, mwb_p;

    logic [CONS_LANES-1:0][2*SEL_W-1:0]    ctrl_q, ctrl_d;

    // Scan is youngest stage first (INT_EX, MEM_MA, INT_WB, MEM_WB), lowest lane first;
    // the first hit wins and later candidates are ignored.
    function automatic bypass_select_t pick(input logic sv, input logic [PREG_WIDTH-1:0] sp);
        bypass_select_t s;
        logic           found;
        s     = '0;
        found = 1'b0;
        for (int l = 0; l < INT_LANES; l++) begin
            if (!found && sv && iex_v[l] && iex_p[l] == sp) begin
                s.valid   = 1'b1;
                s.stg     = STG_INT_EX;
                s.intLane = ILW'(l);
                found     = 1'b1;
            end
        end
        for (int l = 0; l < MEM_LANES; l++) begin
            if (!found && sv && mma_v[l] && mma_p[l] == sp) begin
                s.valid   = 1'b1;
                s.stg     = STG_MEM_MA;
                s.memLane = MLW'(l);
                found     = 1'b1;
            end
        end
        for (int l = 0; l < INT_LANES; l++) begin
            if (!found && sv && iwb_v[l] && iwb_p[l] == sp) begin
                s.valid   = 1'b1;
                s.stg     = STG_INT_WB;
                s.intLane = ILW'(l);
                found     = 1'b1;
            end
        end
        for (int l = 0; l < MEM_LANES; l++) begin
            if (!found && sv && mwb_v[l] && mwb_p[l] == sp) begin
                s.valid   = 1'b1;
                s.stg     = STG_MEM_WB;
                s.memLane = MLW'(l);
                found     = 1'b1;
            end
        end
        return s;
    endfunction

    always_comb begin
        ctrl_d = '0;
        for (int c = 0; c < CONS_LANES; c++) begin
            ctrl_d[c] = {pick(srcAValid[c], src_a_p[c]), pick(srcBValid[c], src_b_p[c])};
        end
    end

    // Flush clears only the valid bits; stale pregs are harmless once invalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            iex_v  <= '0;
            iex_p  <= '0;
            iwb_v  <= '0;
            iwb_p  <= '0;
            mma_v  <= '0;
            mma_p  <= '0;
            mwb_v  <= '0;
            mwb_p  <= '0;
            ctrl_q <= '0;
        end else if (flush) begin
            iex_v  <= '0;
            iwb_v  <= '0;
            mma_v  <= '0;
            mwb_v  <= '0;
            ctrl_q <= '0;
        end else if (!stall) begin
            iwb_v  <= iex_v;
            iwb_p  <= iex_p;
            iex_v  <= intDstValid;
            iex_p  <= int_dst_p;
            mwb_v  <= mma_v;
            mwb_p  <= mma_p;
            mma_v  <= memDstValid;
            mma_p  <= mem_dst_p;
            ctrl_q <= ctrl_d;
        end
    end

    assign bypassCtrl = ctrl_q;

endmodule

// File: tb/tb_bypass_controller.sv
// Directed and randomized checks of bypass_controller against a producer-history
// reference model (ages counted in unstalled cycles).
module tb_bypass_controller;

    localparam int IL = 2, ML = 2, CL = 4, PW = 7;
    localparam int SW = 6;
    localparam int OW = CL * 2 * SW;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              stall = 1'b0;
    logic              flush = 1'b0;
    logic [IL-1:0]     intDstValid = '0;
    logic [IL*PW-1:0]  intDstPreg = '0;
    logic [ML-1:0]     memDstValid = '0;
    logic [ML*PW-1:0]  memDstPreg = '0;
    logic [CL-1:0]     srcAValid = '0;
    logic [CL*PW-1:0]  srcAPreg = '0;
    logic [CL-1:0]     srcBValid = '0;
    logic [CL*PW-1:0]  srcBPreg = '0;
    logic [OW-1:0]     bypassCtrl;

    bypass_controller #(
        .INT_LANES(IL), .MEM_LANES(ML), .CONS_LANES(CL), .PREG_WIDTH(PW)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .intDstValid(intDstValid), .intDstPreg(intDstPreg),
        .memDstValid(memDstValid), .memDstPreg(memDstPreg),
        .srcAValid(srcAValid), .srcAPreg(srcAPreg),
        .srcBValid(srcBValid), .srcBPreg(srcBPreg),
        .bypassCtrl(bypassCtrl)
    );

    always #5 clk = ~clk;

    // One record per unstalled cycle of producers; hist[0] is the newest.
    typedef struct packed {
        logic [IL-1:0]         iv;
        logic [IL-1:0][PW-1:0] ip;
        logic [ML-1:0]         mv;
        logic [ML-1:0][PW-1:0] mp;
    } prod_t;

    prod_t         hist[$];
    logic [OW-1:0] exp_ctrl = '0;
    logic [OW-1:0] held;
    int            tests = 0;
    int            fails = 0;

    task automatic check(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        prod_t z;
        z        = '0;
        hist     = {z, z};
        exp_ctrl = '0;
    endtask

    // Candidate order: age 1 before age 2; integer before memory; lower lane first.
    function automatic logic [SW-1:0] model_sel(input logic v, input logic [PW-1:0] p);
        for (int age = 0; age < 2; age++) begin
            for (int l = 0; l < IL; l++)
                if (v && hist[age].iv[l] && hist[age].ip[l] == p)
                    return {1'b1, (age == 0) ? 2'd0 : 2'd1, 1'(l), 1'b0, 1'b0};
            for (int l = 0; l < ML; l++)
                if (v && hist[age].mv[l] && hist[age].mp[l] == p)
                    return {1'b1, (age == 0) ? 2'd2 : 2'd3, 1'b0, 1'(l), 1'b0};
        end
        return '0;
    endfunction

    task automatic clear_in();
        stall = 0; flush = 0;
        intDstValid = '0; intDstPreg = '0;
        memDstValid = '0; memDstPreg = '0;
        srcAValid = '0; srcAPreg = '0;
        srcBValid = '0; srcBPreg = '0;
    endtask

    task automatic set_cons(input int c, input logic av, input logic [PW-1:0] ap,
                            input logic bv, input logic [PW-1:0] bp);
        srcAValid[c]        = av;
        srcAPreg[c*PW +: PW] = ap;
        srcBValid[c]        = bv;
        srcBPreg[c*PW +: PW] = bp;
    endtask

    // Inputs are set at the falling edge; the model advances, the DUT clocks, and
    // the result is compared at the next falling edge.
    task automatic tick(input string tag);
        prod_t cur;
        if (flush) begin
            model_reset();
        end else if (!stall) begin
            for (int c = 0; c < CL; c++)
                exp_ctrl[c*2*SW +: 2*SW] = {model_sel(srcAValid[c], srcAPreg[c*PW +: PW]),
                                            model_sel(srcBValid[c], srcBPreg[c*PW +: PW])};
            cur.iv = intDstValid; cur.ip = intDstPreg;
            cur.mv = memDstValid; cur.mp = memDstPreg;
            hist.push_front(cur);
            void'(hist.pop_back());
        end
        @(posedge clk);
        @(negedge clk);
        check(tag, bypassCtrl, exp_ctrl);
    endtask

    initial begin
        model_reset();
        #1;
        check("reset_state", bypassCtrl, '0);
        @(negedge clk);
        rst = 1;
        clear_in();
        tick("idle");

        // Back-to-back integer producer on lane 1
        intDstValid[1] = 1; intDstPreg[13:7] = 7'd35;
        tick("b2b_prod");
        clear_in(); set_cons(0, 1, 7'd35, 0, 7'd0);
        tick("b2b_cons");
        check("b2b_lane0", OW'(bypassCtrl[11:0]), OW'({6'b100100, 6'b000000}));

        // Load result ageing from MA to WB to gone
        clear_in(); memDstValid[0] = 1; memDstPreg[6:0] = 7'd12;
        tick("age_prod");
        clear_in(); set_cons(0, 1, 7'd12, 0, 7'd0);
        tick("age_t1");
        check("age_ma", OW'(bypassCtrl[11:6]), OW'(6'b110000));
        tick("age_t2");
        check("age_wb", OW'(bypassCtrl[11:6]), OW'(6'b111000));
        tick("age_t3");
        check("age_gone", OW'(bypassCtrl[11:6]), '0);

        // MEM_MA outranks INT_WB
        clear_in(); intDstValid[0] = 1; intDstPreg[6:0] = 7'd9;
        tick("prio_int");
        clear_in(); memDstValid[1] = 1; memDstPreg[13:7] = 7'd9;
        tick("prio_mem");
        clear_in(); set_cons(0, 0, 7'd0, 1, 7'd9);
        tick("prio_cons");
        check("prio_rb", OW'(bypassCtrl[5:0]), OW'(6'b110010));

        // Stall holds slots and output
        clear_in(); intDstValid[0] = 1; intDstPreg[6:0] = 7'd20;
        set_cons(1, 1, 7'd35, 0, 7'd0);
        tick("stall_prod");
        held = bypassCtrl;
        clear_in(); stall = 1; set_cons(1, 1, 7'd20, 1, 7'd20);
        intDstValid[1] = 1; intDstPreg[13:7] = 7'd20;
        tick("stall_1");
        check("stall_hold1", bypassCtrl, held);
        tick("stall_2");
        check("stall_hold2", bypassCtrl, held);
        clear_in(); set_cons(0, 1, 7'd20, 0, 7'd0);
        tick("stall_cons");
        check("stall_ex", OW'(bypassCtrl[11:6]), OW'(6'b100000));

        // Flush clears output and slots; flush-cycle inputs are dropped
        clear_in(); intDstValid = 2'b11; intDstPreg = {7'd41, 7'd40};
        memDstValid[0] = 1; memDstPreg[6:0] = 7'd42;
        tick("flush_prod");
        clear_in(); set_cons(0, 1, 7'd40, 1, 7'd42);
        tick("flush_pre");
        flush = 1; intDstValid[0] = 1; intDstPreg[6:0] = 7'd41;
        tick("flush_cyc");
        check("flush_zero", bypassCtrl, '0);
        clear_in(); set_cons(0, 1, 7'd40, 1, 7'd41);
        tick("flush_post");
        check("flush_old", bypassCtrl, '0);

        // srcValid gates the match
        clear_in(); intDstValid[0] = 1; intDstPreg[6:0] = 7'd50;
        tick("gate_prod");
        clear_in(); set_cons(2, 0, 7'd50, 1, 7'd50);
        tick("gate_cons");
        check("gate_lane2", OW'(bypassCtrl[35:24]), OW'({6'b000000, 6'b100000}));

        // Asynchronous reset mid-cycle
        clear_in(); intDstValid[0] = 1; intDstPreg[6:0] = 7'd0;
        tick("rst_prod");
        clear_in(); set_cons(3, 1, 7'd0, 0, 7'd0);
        tick("rst_cons");
        check("rst_pre", OW'(bypassCtrl[47:42]), OW'(6'b100000));
        #2;
        rst = 0;
        #1;
        check("rst_async", bypassCtrl, '0);
        model_reset();
        @(negedge clk);
        rst = 1;
        clear_in(); set_cons(3, 1, 7'd0, 0, 7'd0);
        tick("rst_after");

        // Randomized traffic over a small preg space to force collisions
        for (int n = 0; n < 400; n++) begin
            clear_in();
            stall = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 19) == 0);
            intDstValid = 2'($urandom);
            memDstValid = 2'($urandom);
            for (int l = 0; l < IL; l++) intDstPreg[l*PW +: PW] = 7'($urandom_range(0, 7));
            for (int l = 0; l < ML; l++) memDstPreg[l*PW +: PW] = 7'($urandom_range(0, 7));
            for (int c = 0; c < CL; c++)
                set_cons(c, 1'($urandom), 7'($urandom_range(0, 7)),
                         1'($urandom), 7'($urandom_range(0, 7)));
            tick("random");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
